// File: rtl/i2c_init_seq.sv
// Table-driven I2C init sequencer: walks a registered init ROM and issues one
// register write per entry through the downstream I2C master.
module i2c_init_seq #(
  parameter int         TBL_AW    = 8,
  parameter logic [6:0] DEV_ADDR  = 7'h24,
  parameter int         DLY_SHIFT = 10,
  parameter int         TIMEOUT   = 65535
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [23:0]       tbl_data,
  output logic              i2c_run,
  output logic              i2c_rw,
  output logic [6:0]        i2c_dev_addr,
  output logic [15:0]       i2c_ofs_addr,
  output logic [7:0]        i2c_wr_data,
  input  logic              i2c_running,
  input  logic              i2c_done,
  output logic              busy,
  output logic              init_done,
  output logic              timeout_err,
  output logic [TBL_AW:0]   wr_count
);

  localparam int          DLY_W   = 8 + DLY_SHIFT;
  localparam int          TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [15:0] OFS_END = 16'hFFFF;
  localparam logic [15:0] OFS_DLY = 16'hFFFE;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_DELAY, S_NEXT, S_FINISH
  } state_t;

  state_t           state, state_nxt;
  logic [DLY_W-1:0] dly_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [15:0]      ent_ofs;
  logic [7:0]       ent_data;
  logic             ent_end, ent_dly, to_hit;

  assign ent_ofs      = tbl_data[23:8];
  assign ent_data     = tbl_data[7:0];
  assign ent_end      = (ent_ofs == OFS_END);
  assign ent_dly      = (ent_ofs == OFS_DLY);
  assign to_hit       = (to_cnt == TO_W'(TIMEOUT - 1));
  assign i2c_rw       = 1'b0;
  assign i2c_dev_addr = DEV_ADDR;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        if (ent_end)      state_nxt = S_FINISH;
        else if (ent_dly) state_nxt = (ent_data == 8'd0) ? S_NEXT : S_DELAY;
        else              state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (to_hit)           state_nxt = S_IDLE;
        else if (i2c_running) state_nxt = S_WAIT;
      end
      // a completion in the expiry cycle still counts as a good write
      S_WAIT: begin
        if (i2c_done)    state_nxt = S_NEXT;
        else if (to_hit) state_nxt = S_IDLE;
      end
      S_DELAY:  if (dly_cnt == DLY_W'(1)) state_nxt = S_NEXT;
      S_NEXT:   state_nxt = (&tbl_addr) ? S_FINISH : S_FETCH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tbl_addr     <= '0;
      i2c_run      <= 1'b0;
      i2c_ofs_addr <= '0;
      i2c_wr_data  <= '0;
      busy         <= 1'b0;
      init_done    <= 1'b0;
      timeout_err  <= 1'b0;
      wr_count     <= '0;
      dly_cnt      <= '0;
      to_cnt       <= '0;
    end else begin
      init_done <= (state_nxt == S_FINISH);
      case (state)
        S_IDLE: begin
          if (start) begin
            tbl_addr    <= '0;
            wr_count    <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
          end
        end
        S_DECODE: begin
          if (ent_dly) begin
            dly_cnt <= DLY_W'(ent_data) << DLY_SHIFT;
          end else if (!ent_end) begin
            i2c_ofs_addr <= ent_ofs;
            i2c_wr_data  <= ent_data;
            i2c_run      <= 1'b1;
            to_cnt       <= '0;
          end
        end
        // run drops as soon as the master reports running, so it is already
        // low by the time the master can pulse done
        S_ISSUE: begin
          to_cnt <= to_cnt + 1'b1;
          if (to_hit) begin
            i2c_run     <= 1'b0;
            timeout_err <= 1'b1;
            busy        <= 1'b0;
          end else if (i2c_running) begin
            i2c_run <= 1'b0;
          end
        end
        S_WAIT: begin
          if (i2c_done) begin
            wr_count <= wr_count + 1'b1;
          end else if (to_hit) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_DELAY:  dly_cnt <= dly_cnt - 1'b1;
        S_NEXT:   if (!(&tbl_addr)) tbl_addr <= tbl_addr + 1'b1;
        S_FINISH: busy <= 1'b0;
        default:  ;
      endcase
    end
  end

endmodule
